// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and a byte-addressed data memory.
// Misaligned halfword/word accesses can be split into sequential byte accesses.
module lsu_mem_master #(
    parameter int unsigned ADDR_LIMIT       = 4096,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_en,
    output logic        mem_wren,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // resp_valid is a single-cycle pulse and needs no acknowledge.
    typedef enum logic [2:0] {IDLE, CHECK, ACCESS, SPLIT, DONE} state_t;

    state_t      state;
    logic        l_we;
    logic [2:0]  l_op;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [1:0]  k;
    logic [31:0] asm_buf;

    logic [2:0]  size;
    logic        op_legal;
    logic        misaligned;
    logic        range_err;
    logic        chk_err;
    logic [32:0] last_byte;
    logic [1:0]  k_inc;
    logic        last_beat;
    logic [31:0] asm_next;
    logic [31:0] split_result;

    always_comb begin
        case (l_op[1:0])
            2'b00:   size = 3'd4;
            2'b01:   size = 3'd1;
            2'b10:   size = 3'd2;
            default: size = 3'd0;
        endcase
        op_legal   = (l_op == 3'b000) || (l_op == 3'b001) || (l_op == 3'b010) ||
                     (!l_we && ((l_op == 3'b101) || (l_op == 3'b110)));
        // 33-bit sum so an access wrapping past 2^32 is seen as out of range
        last_byte  = {1'b0, l_addr} + {30'b0, size} - 33'd1;
        range_err  = last_byte >= 33'(ADDR_LIMIT);
        misaligned = ((size == 3'd4) && (l_addr[1:0] != 2'b00)) ||
                     ((size == 3'd2) && l_addr[0]);
        chk_err    = !op_legal || range_err || (misaligned && !SPLIT_MISALIGNED);

        k_inc     = k + 2'd1;
        last_beat = ({1'b0, k} == (size - 3'd1));
        asm_next  = asm_buf;
        asm_next[8*k +: 8] = mem_rdata[7:0];
        split_result = asm_next;
        if (size == 3'd2) begin
            split_result = l_op[2] ? {16'b0, asm_next[15:0]}
                                   : {{16{asm_next[15]}}, asm_next[15:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'b0;
            mem_en     <= 1'b0;
            mem_wren   <= 1'b0;
            mem_op     <= 3'b000;
            mem_addr   <= 32'b0;
            mem_wdata  <= 32'b0;
            l_we       <= 1'b0;
            l_op       <= 3'b000;
            l_addr     <= 32'b0;
            l_wdata    <= 32'b0;
            k          <= 2'd0;
            asm_buf    <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_we      <= req_we;
                        l_op      <= req_op;
                        l_addr    <= req_addr;
                        l_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (chk_err) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'b0;
                        state      <= DONE;
                    end else if (!misaligned) begin
                        mem_en    <= 1'b1;
                        mem_wren  <= l_we;
                        mem_op    <= l_op;
                        mem_addr  <= l_addr;
                        mem_wdata <= l_wdata;
                        state     <= ACCESS;
                    end else begin
                        k         <= 2'd0;
                        asm_buf   <= 32'b0;
                        mem_en    <= 1'b1;
                        mem_wren  <= l_we;
                        mem_op    <= l_we ? 3'b001 : 3'b101;
                        mem_addr  <= l_addr;
                        mem_wdata <= {24'b0, l_wdata[7:0]};
                        state     <= SPLIT;
                    end
                end
                ACCESS: begin
                    mem_en     <= 1'b0;
                    mem_wren   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= l_we ? 32'b0 : mem_rdata;
                    state      <= DONE;
                end
                SPLIT: begin
                    if (last_beat) begin
                        mem_en     <= 1'b0;
                        mem_wren   <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= l_we ? 32'b0 : split_result;
                        state      <= DONE;
                    end else begin
                        k         <= k_inc;
                        asm_buf   <= asm_next;
                        mem_addr  <= l_addr + {30'b0, k_inc};
                        mem_wdata <= {24'b0, l_wdata[8*k_inc +: 8]};
                    end
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte memory model, spec-level reference model with
// expected queues, per-cycle compare process, directed and randomized requests.
module tb_lsu_mem_master;

    localparam int LIMIT = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_op = 3'b0;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic        req_ready, resp_valid, resp_err, mem_en, mem_wren;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_op;

    logic        ns_req_valid = 1'b0;
    logic [2:0]  ns_req_op = 3'b0;
    logic [31:0] ns_req_addr = 32'b0;
    logic        ns_req_ready, ns_resp_valid, ns_resp_err, ns_mem_en, ns_mem_wren;
    logic [31:0] ns_resp_rdata, ns_mem_addr, ns_mem_wdata, ns_mem_rdata;
    logic [2:0]  ns_mem_op;

    lsu_mem_master #(.ADDR_LIMIT(LIMIT), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_en(mem_en), .mem_wren(mem_wren), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_mem_master #(.ADDR_LIMIT(LIMIT), .SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .req_valid(ns_req_valid), .req_ready(ns_req_ready),
        .req_we(1'b0), .req_op(ns_req_op), .req_addr(ns_req_addr), .req_wdata(32'h5a5a_5a5a),
        .resp_valid(ns_resp_valid), .resp_err(ns_resp_err), .resp_rdata(ns_resp_rdata),
        .mem_en(ns_mem_en), .mem_wren(ns_mem_wren), .mem_op(ns_mem_op), .mem_addr(ns_mem_addr),
        .mem_wdata(ns_mem_wdata), .mem_rdata(ns_mem_rdata)
    );

    logic [7:0] mem     [0:LIMIT-1];
    logic [7:0] ref_mem [0:LIMIT-1];

    function automatic logic [31:0] rd_fn(input logic [31:0] a, input logic [2:0] op);
        logic [11:0] i;
        logic [31:0] w;
        i = a[11:0];
        w = {mem[i + 12'd3], mem[i + 12'd2], mem[i + 12'd1], mem[i]};
        case (op)
            3'b000:  rd_fn = w;
            3'b001:  rd_fn = {{24{w[7]}}, w[7:0]};
            3'b101:  rd_fn = {24'b0, w[7:0]};
            3'b010:  rd_fn = {{16{w[15]}}, w[15:0]};
            3'b110:  rd_fn = {16'b0, w[15:0]};
            default: rd_fn = 32'b0;
        endcase
    endfunction

    always_comb mem_rdata    = rd_fn(mem_addr, mem_op);
    always_comb ns_mem_rdata = rd_fn(ns_mem_addr, ns_mem_op);

    always @(posedge clk) begin
        if (!rst && mem_en && mem_wren) begin
            case (mem_op)
                3'b000: begin
                    mem[mem_addr[11:0]]         <= mem_wdata[7:0];
                    mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
                    mem[mem_addr[11:0] + 12'd2] <= mem_wdata[23:16];
                    mem[mem_addr[11:0] + 12'd3] <= mem_wdata[31:24];
                end
                3'b010: begin
                    mem[mem_addr[11:0]]         <= mem_wdata[7:0];
                    mem[mem_addr[11:0] + 12'd1] <= mem_wdata[15:8];
                end
                3'b001: mem[mem_addr[11:0]] <= mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // beat: {check_wdata, wren, op[2:0], addr[31:0], wdata[31:0]}; resp: {err, rdata[31:0], lat[7:0]}
    logic [68:0] exp_beat_q[$];
    logic [40:0] exp_resp_q[$];
    int          accept_edge = 0;
    int          resp_seen = 0;
    logic        last_err;
    logic [31:0] last_rdata;

    function automatic int nbytes(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 4;
            2'b01:   return 1;
            2'b10:   return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr);
        int n;
        logic [31:0] v;
        logic [31:0] a;
        n = nbytes(op);
        v = 32'b0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            v = v | (32'(ref_mem[a[11:0]]) << (8 * i));
        end
        if (n == 1) return op[2] ? v : {{24{v[7]}}, v[7:0]};
        if (n == 2) return op[2] ? v : {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic model_push(input logic we, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        logic legal, mis, err;
        logic [63:0] last;
        logic [31:0] rdata, a;
        logic [7:0] b;
        n     = nbytes(op);
        legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) ||
                (!we && ((op == 3'd5) || (op == 3'd6)));
        last  = {32'b0, addr} + 64'(n) - 64'd1;
        mis   = (n != 0) && ((addr % 32'(n)) != 0);
        err   = !legal || (last >= 64'(LIMIT));
        if (err) begin
            exp_resp_q.push_back({1'b1, 32'b0, 8'd2});
        end else begin
            rdata = we ? 32'b0 : model_load(op, addr);
            if (!mis) exp_beat_q.push_back({1'b1, we, op, addr, wdata});
            for (int i = 0; i < n; i++) begin
                a = addr + 32'(i);
                b = 8'((wdata >> (8 * i)) & 32'hff);
                if (mis) exp_beat_q.push_back({we, we, (we ? 3'b001 : 3'b101), a, {24'b0, b}});
                if (we) ref_mem[a[11:0]] = b;
            end
            exp_resp_q.push_back({1'b0, rdata, (mis ? 8'(n + 2) : 8'd3)});
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (exp_beat_q.size() == 0) begin
                    check("unexpected_mem_en", 32'(mem_en), 32'd0);
                end else begin
                    logic [68:0] bt;
                    bt = exp_beat_q.pop_front();
                    check("mem_wren", 32'(mem_wren), 32'(bt[67]));
                    check("mem_op",   32'(mem_op),   32'(bt[66:64]));
                    check("mem_addr", mem_addr,      bt[63:32]);
                    if (bt[68]) check("mem_wdata", mem_wdata, bt[31:0]);
                end
            end else if (mem_wren) begin
                check("mem_wren_without_en", 32'(mem_wren), 32'd0);
            end
            if (resp_valid) begin
                if (exp_resp_q.size() == 0) begin
                    check("unexpected_resp_valid", 32'(resp_valid), 32'd0);
                end else begin
                    logic [40:0] rs;
                    rs = exp_resp_q.pop_front();
                    check("resp_err",    32'(resp_err), 32'(rs[40]));
                    check("resp_rdata",  resp_rdata,    rs[39:8]);
                    check("resp_latency", 32'(cyc - accept_edge + 1), 32'(rs[7:0]));
                    check("req_ready_in_done", 32'(req_ready), 32'd0);
                    check("beats_done_at_resp", 32'(exp_beat_q.size()), 32'd0);
                end
                last_err   = resp_err;
                last_rdata = resp_rdata;
                resp_seen++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit pin,
                          input logic pin_err, input logic [31:0] pin_rdata);
        int t;
        int target;
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL accept_timeout: req_ready stayed 0, required 1");
            req_valid = 1'b0;
            return;
        end
        target = resp_seen + 1;
        accept_edge = cyc + 1;
        model_push(we, op, addr, wdata);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom_range(0, 1)); req_op = 3'($urandom_range(0, 7));
        req_addr = $urandom; req_wdata = $urandom;
        t = 0;
        while (resp_seen < target && t < 30) begin
            @(negedge clk);
            #1;
            t++;
        end
        checks++;
        if (resp_seen < target) begin
            errors++;
            $display("FAIL resp_timeout: no resp_valid within 30 cycles, required 1");
            exp_beat_q.delete();
            exp_resp_q.delete();
            return;
        end
        if (pin) begin
            check("pin_err",   32'(last_err), 32'(pin_err));
            check("pin_rdata", last_rdata,    pin_rdata);
        end
    endtask

    task automatic ns_req(input logic [2:0] op, input logic [31:0] addr,
                          input logic exp_err, input int exp_en);
        int t;
        int en_cnt;
        bit got;
        logic [31:0] exp_rdata;
        exp_rdata = exp_err ? 32'b0 : model_load(op, addr);
        ns_req_valid = 1'b1; ns_req_op = op; ns_req_addr = addr;
        t = 0;
        while (!ns_req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        ns_req_valid = 1'b0;
        en_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (ns_mem_en) en_cnt++;
            if (ns_resp_valid) begin
                got = 1'b1;
                check("ns_resp_err",   32'(ns_resp_err), 32'(exp_err));
                check("ns_resp_rdata", ns_resp_rdata,    exp_rdata);
            end
        end
        check("ns_resp_seen", 32'(got), 32'd1);
        check("ns_mem_en_cycles", 32'(en_cnt), 32'(exp_en));
        #1;
    endtask

    task automatic reset_mid_split();
        logic [7:0] m33, m34;
        int t;
        m33 = ref_mem[12'h033];
        m34 = ref_mem[12'h034];
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b000;
        req_addr = 32'h31; req_wdata = 32'ha1b2c3d4;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        accept_edge = cyc + 1;
        exp_beat_q.push_back({1'b1, 1'b1, 3'b001, 32'h31, 32'h0000_00d4});
        exp_beat_q.push_back({1'b1, 1'b1, 3'b001, 32'h32, 32'h0000_00c3});
        ref_mem[12'h031] = 8'hd4;
        ref_mem[12'h032] = 8'hc3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mem_en",    32'(mem_en),    32'd0);
        check("rst_mem_wren",  32'(mem_wren),  32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_beats_consumed", 32'(exp_beat_q.size()), 32'd0);
        exp_beat_q.delete();
        exp_resp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_byte_31", 32'(mem[12'h031]), 32'h0000_00d4);
        check("rst_byte_32", 32'(mem[12'h032]), 32'h0000_00c3);
        check("rst_byte_33", 32'(mem[12'h033]), 32'(m33));
        check("rst_byte_34", 32'(mem[12'h034]), 32'(m34));
        do_req(1'b0, 3'b000, 32'h30, 32'h0, 1'b1, 1'b0, model_load(3'b000, 32'h30));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < LIMIT; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (2) @(negedge clk);
        check("reset_req_ready",  32'(req_ready),  32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_resp_err",   32'(resp_err),   32'd0);
        check("reset_resp_rdata", resp_rdata,      32'd0);
        check("reset_mem_en",     32'(mem_en),     32'd0);
        check("reset_mem_wren",   32'(mem_wren),   32'd0);
        check("reset_mem_op",     32'(mem_op),     32'd0);
        check("reset_mem_addr",   mem_addr,        32'd0);
        check("reset_mem_wdata",  mem_wdata,       32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b1, 3'b000, 32'h10, 32'hdeadbeef, 1'b1, 1'b0, 32'h0);
        do_req(1'b0, 3'b000, 32'h10, 32'h0, 1'b1, 1'b0, 32'hdeadbeef);
        do_req(1'b0, 3'b001, 32'h10, 32'h0, 1'b1, 1'b0, 32'hffffffef);
        do_req(1'b0, 3'b101, 32'h10, 32'h0, 1'b1, 1'b0, 32'h000000ef);
        do_req(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 1'b0, 32'hffffdead);
        do_req(1'b0, 3'b110, 32'h12, 32'h0, 1'b1, 1'b0, 32'h0000dead);
        do_req(1'b1, 3'b001, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
        do_req(1'b1, 3'b000, 32'h21, 32'h11223344, 1'b1, 1'b0, 32'h0);
        do_req(1'b0, 3'b000, 32'h20, 32'h0, 1'b1, 1'b0, 32'h22334400);
        do_req(1'b1, 3'b001, 32'h13, 32'h80, 1'b1, 1'b0, 32'h0);
        do_req(1'b1, 3'b001, 32'h14, 32'h01, 1'b1, 1'b0, 32'h0);
        do_req(1'b0, 3'b010, 32'h13, 32'h0, 1'b1, 1'b0, 32'h00000180);
        do_req(1'b0, 3'b110, 32'h13, 32'h0, 1'b1, 1'b0, 32'h00000180);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0);
        do_req(1'b1, 3'b101, 32'h10, 32'h12345678, 1'b1, 1'b1, 32'h0);
        do_req(1'b0, 3'b000, 32'(LIMIT - 2), 32'h0, 1'b1, 1'b1, 32'h0);
        do_req(1'b0, 3'b000, 32'hffff_fffe, 32'h0, 1'b1, 1'b1, 32'h0);
        do_req(1'b0, 3'b000, 32'(LIMIT - 4), 32'h0, 1'b1, 1'b0, model_load(3'b000, 32'(LIMIT - 4)));

        ns_req(3'b010, 32'h01, 1'b1, 0);
        ns_req(3'b000, 32'h10, 1'b0, 1);
        ns_req(3'b010, 32'h12, 1'b0, 1);

        reset_mid_split();

        for (int it = 0; it < 200; it++) begin
            logic [2:0]  op_tab [8];
            logic [2:0]  op;
            logic [31:0] addr;
            int r;
            op_tab = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd3, 3'd4, 3'd7};
            op = ($urandom_range(0, 9) < 8) ? op_tab[$urandom_range(0, 4)] : op_tab[$urandom_range(5, 7)];
            r = $urandom_range(0, 19);
            if (r < 17)      addr = 32'($urandom_range(0, 63));
            else if (r < 19) addr = 32'(LIMIT - $urandom_range(1, 6));
            else             addr = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(1'($urandom_range(0, 1)), op, addr, $urandom, 1'b0, 1'b0, 32'h0);
        end

        repeat (3) @(negedge clk);
        check("final_beat_queue_empty", 32'(exp_beat_q.size()), 32'd0);
        check("final_resp_queue_empty", 32'(exp_resp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
